// File: rtl/port_ctrl_pkg.sv
// port_ctrl_pkg: shared definitions for the tri-state port controller.
//   - register address map (port_addr_e)
//   - debounce counter width
//   - helper that turns a debounce length into the counter terminal value
package port_ctrl_pkg;

   // CPU-visible register map; 6 and 7 are reserved (read 0, writes ignored)
   typedef enum logic [2:0] {
      PORT_ADDR_DIR     = 3'd0,
      PORT_ADDR_OUT     = 3'd1,
      PORT_ADDR_IN      = 3'd2,
      PORT_ADDR_RISE_EN = 3'd3,
      PORT_ADDR_FALL_EN = 3'd4,
      PORT_ADDR_STATUS  = 3'd5,
      PORT_ADDR_RSVD6   = 3'd6,
      PORT_ADDR_RSVD7   = 3'd7
   } port_addr_e;

   localparam int PORT_CNT_W = 8;

   // Counter value at which a differing synchronized value is accepted
   function automatic logic [PORT_CNT_W-1:0] deb_last(input int deb_cnt);
      return PORT_CNT_W'(deb_cnt - 1);
   endfunction

endpackage

// File: rtl/port_ctrl_if.sv
// port_ctrl_if: CPU register bus of the port controller.
//   wr_en  - register write strobe
//   rd_en  - register read strobe
//   addr   - register address (see port_addr_e)
//   wdata  - write data
//   rdata  - registered read data, valid the cycle after rd_en
// Modports: master (CPU side) drives the strobes, slave (port_ctrl) returns rdata.
interface port_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             wr_en;
   logic             rd_en;
   logic [2:0]       addr;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] rdata;

   modport master (
      output wr_en,
      output rd_en,
      output addr,
      output wdata,
      input  rdata
   );

   modport slave (
      input  wr_en,
      input  rd_en,
      input  addr,
      input  wdata,
      output rdata
   );
endinterface

// File: rtl/port_ctrl_debounce.sv
// port_debounce: one pin's input path.
//   clk, rst - clock and synchronous active-high reset
//   pin      - asynchronous pin value from the port cell
//   deb      - debounced value (flop)
//   rise     - pulse in the cycle whose edge moves deb 0->1
//   fall     - pulse in the cycle whose edge moves deb 1->0
// The pin is brought in through two flops; deb only follows once the
// synchronized value has differed from it for DEB_CNT consecutive cycles.
module port_debounce
   import port_ctrl_pkg::*;
#(
   parameter int DEB_CNT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic deb,
   output logic rise,
   output logic fall
);

   localparam logic [PORT_CNT_W-1:0] DEB_LAST = deb_last(DEB_CNT);

   logic                  s1_r;
   logic                  s2_r;
   logic                  deb_r;
   logic [PORT_CNT_W-1:0] cnt_r;
   logic                  expire_s;
   logic                  rise_s;
   logic                  fall_s;

   // Decide whether this edge accepts the new value, and in which direction
   always_comb begin
      expire_s = 1'b0;
      rise_s   = 1'b0;
      fall_s   = 1'b0;
      if ((s2_r != deb_r) && (cnt_r == DEB_LAST)) begin
         expire_s = 1'b1;
         rise_s   = s2_r;
         fall_s   = ~s2_r;
      end else begin
         expire_s = 1'b0;
      end
   end

   // Synchronizer, debounce counter and debounced value
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_r  <= 1'b0;
         s2_r  <= 1'b0;
         deb_r <= 1'b0;
         cnt_r <= {PORT_CNT_W{1'b0}};
      end else begin
         s1_r <= pin;
         s2_r <= s1_r;
         if (s2_r == deb_r) begin
            cnt_r <= {PORT_CNT_W{1'b0}};
         end else if (expire_s) begin
            deb_r <= s2_r;
            cnt_r <= {PORT_CNT_W{1'b0}};
         end else begin
            cnt_r <= cnt_r + PORT_CNT_W'(1);
         end
      end
   end

   assign deb  = deb_r;
   assign rise = rise_s;
   assign fall = fall_s;

endmodule

// File: rtl/port_ctrl.sv
// port_ctrl: register-mapped controller for a bank of tri-state pins.
//   clk, rst      - clock and synchronous active-high reset
//   bus           - CPU register bus (port_ctrl_if.slave)
//   drive_enable  - per-pin drive enable (DIR register)
//   drive_value   - per-pin output value (OUT register)
//   port_value    - per-pin pin value, asynchronous
//   irq           - high while any STATUS bit is set
// Holds the register file, the sticky edge status and the read mux; the
// per-pin input path lives in port_debounce.
module port_ctrl
   import port_ctrl_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int DEB_CNT = 4
) (
   input  logic             clk,
   input  logic             rst,
   port_ctrl_if.slave       bus,
   output logic [WIDTH-1:0] drive_enable,
   output logic [WIDTH-1:0] drive_value,
   input  logic [WIDTH-1:0] port_value,
   output logic             irq
);

   logic [WIDTH-1:0] dir_r;
   logic [WIDTH-1:0] out_r;
   logic [WIDTH-1:0] rise_en_r;
   logic [WIDTH-1:0] fall_en_r;
   logic [WIDTH-1:0] status_r;
   logic [WIDTH-1:0] rdata_r;
   logic             irq_r;

   logic [WIDTH-1:0] deb_s;
   logic [WIDTH-1:0] rise_s;
   logic [WIDTH-1:0] fall_s;

   port_addr_e       addr_s;
   logic             wr_dir_s;
   logic             wr_out_s;
   logic             wr_rise_en_s;
   logic             wr_fall_en_s;
   logic [WIDTH-1:0] status_clr_s;
   logic [WIDTH-1:0] status_set_s;
   logic [WIDTH-1:0] status_next_s;
   logic [WIDTH-1:0] rd_mux_s;

   assign addr_s = port_addr_e'(bus.addr);

   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      port_debounce #(
         .DEB_CNT (DEB_CNT)
      ) u_deb (
         .clk  (clk),
         .rst  (rst),
         .pin  (port_value[i]),
         .deb  (deb_s[i]),
         .rise (rise_s[i]),
         .fall (fall_s[i])
      );
   end

   // Write decode; IN and the reserved addresses have no write strobe
   always_comb begin
      wr_dir_s     = 1'b0;
      wr_out_s     = 1'b0;
      wr_rise_en_s = 1'b0;
      wr_fall_en_s = 1'b0;
      status_clr_s = {WIDTH{1'b0}};
      if (bus.wr_en) begin
         case (addr_s)
            PORT_ADDR_DIR:     wr_dir_s     = 1'b1;
            PORT_ADDR_OUT:     wr_out_s     = 1'b1;
            PORT_ADDR_RISE_EN: wr_rise_en_s = 1'b1;
            PORT_ADDR_FALL_EN: wr_fall_en_s = 1'b1;
            PORT_ADDR_STATUS:  status_clr_s = bus.wdata;
            default:           status_clr_s = {WIDTH{1'b0}};
         endcase
      end else begin
         status_clr_s = {WIDTH{1'b0}};
      end
   end

   // Sticky status: the set term is applied after the clear so a
   // coincident event is never lost to a write-1-to-clear
   always_comb begin
      status_set_s  = (rise_s & rise_en_r) | (fall_s & fall_en_r);
      status_next_s = (status_r & ~status_clr_s) | status_set_s;
   end

   // Read mux; sampled into rdata_r only on rd_en
   always_comb begin
      rd_mux_s = {WIDTH{1'b0}};
      case (addr_s)
         PORT_ADDR_DIR:     rd_mux_s = dir_r;
         PORT_ADDR_OUT:     rd_mux_s = out_r;
         PORT_ADDR_IN:      rd_mux_s = deb_s;
         PORT_ADDR_RISE_EN: rd_mux_s = rise_en_r;
         PORT_ADDR_FALL_EN: rd_mux_s = fall_en_r;
         PORT_ADDR_STATUS:  rd_mux_s = status_r;
         default:           rd_mux_s = {WIDTH{1'b0}};
      endcase
   end

   // Register file, status, irq and read data
   always_ff @(posedge clk) begin
      if (rst) begin
         dir_r     <= {WIDTH{1'b0}};
         out_r     <= {WIDTH{1'b0}};
         rise_en_r <= {WIDTH{1'b0}};
         fall_en_r <= {WIDTH{1'b0}};
         status_r  <= {WIDTH{1'b0}};
         rdata_r   <= {WIDTH{1'b0}};
         irq_r     <= 1'b0;
      end else begin
         if (wr_dir_s)     dir_r     <= bus.wdata;
         if (wr_out_s)     out_r     <= bus.wdata;
         if (wr_rise_en_s) rise_en_r <= bus.wdata;
         if (wr_fall_en_s) fall_en_r <= bus.wdata;
         status_r <= status_next_s;
         // irq tracks the status value being loaded so both change together
         irq_r    <= |status_next_s;
         // read sees pre-edge register contents, so read+write returns old data
         if (bus.rd_en) rdata_r <= rd_mux_s;
      end
   end

   assign drive_enable = dir_r;
   assign drive_value  = out_r;
   assign irq          = irq_r;
   assign bus.rdata    = rdata_r;

endmodule

// File: tb/tb_port_ctrl.sv
// tb_port_ctrl: self-checking bench for port_ctrl (WIDTH=8, DEB_CNT=4).
// Read expectations are queued when a read is issued and compared by a
// monitor when rdata becomes valid; drive/irq are checked directly.
module tb_port_ctrl;
   import port_ctrl_pkg::*;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] drive_enable;
   logic [WIDTH-1:0] drive_value;
   logic [WIDTH-1:0] port_value;
   logic             irq;

   int checks   = 0;
   int failures = 0;

   logic [WIDTH-1:0] sb_q[$];
   logic             rd_pend = 1'b0;

   port_ctrl_if #(.WIDTH(WIDTH)) bus ();

   port_ctrl #(
      .WIDTH   (WIDTH),
      .DEB_CNT (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .drive_enable (drive_enable),
      .drive_value  (drive_value),
      .port_value   (port_value),
      .irq          (irq)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Track which edges sampled a read
   always @(posedge clk) rd_pend <= bus.rd_en && !rst;

   // Scoreboard: compare rdata against the oldest queued expectation
   always @(negedge clk) begin
      if (rd_pend) begin
         if (sb_q.size() == 0) begin
            check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
         end else begin
            check_eq("rdata", 32'(bus.rdata), 32'(sb_q.pop_front()));
         end
      end
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_write(input port_addr_e a, input logic [WIDTH-1:0] d);
      bus.wr_en = 1'b1;
      bus.addr  = a;
      bus.wdata = d;
      tick();
      bus.wr_en = 1'b0;
   endtask

   task automatic do_read(input port_addr_e a, input logic [WIDTH-1:0] exp);
      bus.rd_en = 1'b1;
      bus.addr  = a;
      sb_q.push_back(exp);
      tick();
      bus.rd_en = 1'b0;
   endtask

   task automatic do_rw(input port_addr_e a, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp);
      bus.wr_en = 1'b1;
      bus.rd_en = 1'b1;
      bus.addr  = a;
      bus.wdata = d;
      sb_q.push_back(exp);
      tick();
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      port_value = 8'h00;
      bus.wr_en  = 1'b0;
      bus.rd_en  = 1'b0;
      bus.addr   = 3'd0;
      bus.wdata  = 8'h00;
      tick(3);
      rst = 1'b0;

      // reset state
      check_eq("rst_drive_enable", 32'(drive_enable), 32'h00);
      check_eq("rst_drive_value", 32'(drive_value), 32'h00);
      check_eq("rst_irq", 32'(irq), 32'h0);
      do_read(PORT_ADDR_STATUS, 8'h00);

      // drive path and readback
      do_write(PORT_ADDR_DIR, 8'h0F);
      check_eq("drive_enable", 32'(drive_enable), 32'h0F);
      do_write(PORT_ADDR_OUT, 8'h05);
      check_eq("drive_value", 32'(drive_value), 32'h05);
      do_read(PORT_ADDR_DIR, 8'h0F);
      do_read(PORT_ADDR_OUT, 8'h05);

      // pin 0 rise: irq exactly 6 edges after the change
      do_write(PORT_ADDR_RISE_EN, 8'h01);
      port_value[0] = 1'b1;
      tick(5);
      check_eq("rise_irq_early", 32'(irq), 32'h0);
      tick();
      check_eq("rise_irq_on_time", 32'(irq), 32'h1);
      do_read(PORT_ADDR_IN, 8'h01);
      do_read(PORT_ADDR_STATUS, 8'h01);
      do_write(PORT_ADDR_STATUS, 8'h01);
      check_eq("clr_irq", 32'(irq), 32'h0);

      // 3-cycle glitch on pin 1 is filtered
      port_value[1] = 1'b1;
      tick(3);
      port_value[1] = 1'b0;
      tick(8);
      check_eq("glitch_irq", 32'(irq), 32'h0);
      do_read(PORT_ADDR_IN, 8'h01);

      // 4-cycle pulse passes, no enable for pin 1 -> no status
      port_value[1] = 1'b1;
      tick(4);
      port_value[1] = 1'b0;
      tick(2);
      do_read(PORT_ADDR_IN, 8'h03);
      tick(5);
      do_read(PORT_ADDR_IN, 8'h01);
      check_eq("pulse_noen_irq", 32'(irq), 32'h0);

      // enabling does not create an event by itself
      do_write(PORT_ADDR_RISE_EN, 8'h03);
      do_write(PORT_ADDR_FALL_EN, 8'h02);
      check_eq("enable_no_event", 32'(irq), 32'h0);
      port_value[1] = 1'b1;
      tick(4);
      port_value[1] = 1'b0;
      tick(10);
      do_read(PORT_ADDR_STATUS, 8'h02);
      check_eq("pulse_en_irq", 32'(irq), 32'h1);

      // partial clear keeps irq high
      do_write(PORT_ADDR_FALL_EN, 8'h03);
      port_value[0] = 1'b0;
      tick(7);
      do_read(PORT_ADDR_STATUS, 8'h03);
      do_write(PORT_ADDR_STATUS, 8'h01);
      check_eq("partial_clr_irq", 32'(irq), 32'h1);
      do_read(PORT_ADDR_STATUS, 8'h02);

      // clear coinciding with a new pin-1 event: set wins
      port_value[1] = 1'b1;
      tick(5);
      do_write(PORT_ADDR_STATUS, 8'h02);
      check_eq("set_wins_irq", 32'(irq), 32'h1);
      do_read(PORT_ADDR_STATUS, 8'h02);
      do_write(PORT_ADDR_STATUS, 8'h02);
      check_eq("clr_after_set_irq", 32'(irq), 32'h0);
      do_read(PORT_ADDR_STATUS, 8'h00);

      // reset with pin-2 counter at 2
      port_value[2] = 1'b1;
      tick(4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("midrst_drive_enable", 32'(drive_enable), 32'h00);
      check_eq("midrst_drive_value", 32'(drive_value), 32'h00);
      check_eq("midrst_irq", 32'(irq), 32'h0);
      do_write(PORT_ADDR_RISE_EN, 8'h04);
      tick(4);
      check_eq("midrst_irq_early", 32'(irq), 32'h0);
      tick();
      check_eq("midrst_irq_on_time", 32'(irq), 32'h1);
      do_read(PORT_ADDR_IN, 8'h06);
      do_read(PORT_ADDR_STATUS, 8'h04);

      // reserved addresses and read-only IN
      do_read(PORT_ADDR_RSVD6, 8'h00);
      do_read(PORT_ADDR_RSVD7, 8'h00);
      do_write(PORT_ADDR_IN, 8'hFF);
      do_read(PORT_ADDR_IN, 8'h06);

      // read and write to the same register in one cycle returns old data
      do_rw(PORT_ADDR_DIR, 8'hA5, 8'h00);
      do_read(PORT_ADDR_DIR, 8'hA5);
      check_eq("rw_drive_enable", 32'(drive_enable), 32'hA5);

      tick(2);
      check_eq("sb_drain", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog so the run always terminates
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
